// File: rtl/counter_bus_reader.sv
// ============================================================================
// Module   : counter_bus_reader
// Brief    : Read-only initiator for the multiplexed ale/rd/wr/ad counter bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_bus_reader #(
    parameter int SIZE        = 8,
    parameter int ALE_CYCLES  = 2,
    parameter int TURN_CYCLES = 1,
    parameter int RD_CYCLES   = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_i,
    input  logic [1:0]      addr_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [SIZE-1:0] data_o,
    output logic            ale_o,
    output logic            rd_o,
    output logic            wr_o,
    inout  wire  [SIZE-1:0] ad_io
);

    localparam int CW = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_TURN  = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_RECOV = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      addr_q, addr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [SIZE-1:0] data_q, data_d;
    logic            oe;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    busy_d  = 1'b1;
                    cnt_d   = CW'(ALE_CYCLES - 1);
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (cnt_q == '0) state_d = S_HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_HOLD: begin
                cnt_d   = CW'(TURN_CYCLES - 1);
                state_d = S_TURN;
            end
            S_TURN: begin
                if (cnt_q == '0) begin
                    cnt_d   = CW'(RD_CYCLES - 1);
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_READ: begin
                // Sample on the edge that closes the last rd-low cycle.
                if (cnt_q == '0) begin
                    data_d  = ad_io;
                    done_d  = 1'b1;
                    state_d = S_RECOV;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RECOV: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    // Bus strobes decode straight from state so an async reset releases them at once.
    assign oe     = (state_q == S_ADDR) || (state_q == S_HOLD);
    assign ale_o  = (state_q == S_ADDR);
    assign rd_o   = (state_q != S_READ);
    assign wr_o   = 1'b1;
    assign ad_io  = oe ? {{(SIZE-2){1'b0}}, addr_q} : {SIZE{1'bz}};
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign data_o = data_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_bus_reader.sv
// Directed bench for counter_bus_reader with a behavioural encoder-counter model on the bus.
`default_nettype none

module tb_counter_bus_reader;

    localparam int SIZE    = 8;
    localparam int ALE_C   = 2;
    localparam int TURN_C  = 1;
    localparam int RD_C    = 2;
    localparam int DONE_AT = ALE_C + 1 + TURN_C + RD_C;
    localparam int SPACING = ALE_C + TURN_C + RD_C + 3;
    localparam logic [SIZE-1:0] RELEASED = {SIZE{1'b1}};

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req = 1'b0;
    logic [1:0]      addr = 2'd0;
    logic            busy, done, ale, rd, wr;
    logic [SIZE-1:0] data;
    tri1  [SIZE-1:0] ad;

    // Counter model: latches the select on the falling edge of ale, returns bits [8:1].
    logic [8:0] count [4];
    logic [1:0] sel_q = 2'd0;
    assign ad = (rd == 1'b0) ? count[sel_q][8:1] : {SIZE{1'bz}};
    always @(negedge ale) sel_q <= ad[1:0];

    int n_tests = 0;
    int n_fail  = 0;

    counter_bus_reader #(
        .SIZE(SIZE), .ALE_CYCLES(ALE_C), .TURN_CYCLES(TURN_C), .RD_CYCLES(RD_C)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr),
        .busy_o(busy), .done_o(done), .data_o(data),
        .ale_o(ale), .rd_o(rd), .wr_o(wr), .ad_io(ad)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents req for exactly one sampling edge (E0); returns just after E0.
    task automatic start_req(input logic [1:0] a);
        req  = 1'b1;
        addr = a;
        tick();
        req  = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (done) begin
                cyc = k;
                return;
            end
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    // Bus monitor: turnaround before rd falls, no ale/rd overlap.
    logic            prev_rd = 1'b1;
    logic [SIZE-1:0] prev_ad = '1;
    always @(negedge clk) begin
        if (rd == 1'b0) begin
            check("ale_rd_overlap", {31'd0, ale}, 32'd0);
            if (prev_rd == 1'b1) check("turnaround_before_rd", {24'd0, prev_ad}, {24'd0, RELEASED});
        end
        prev_rd <= rd;
        prev_ad <= ad;
    end

    initial begin
        int c, c1, c2, ndone;
        count[0] = 9'h1F3;
        count[1] = {8'hC3, 1'b1};
        count[2] = {8'h5A, 1'b0};
        count[3] = {8'h3C, 1'b0};

        // Reset state
        #1;
        check("rst_ale",  {31'd0, ale},  32'd0);
        check("rst_rd",   {31'd0, rd},   32'd1);
        check("rst_wr",   {31'd0, wr},   32'd1);
        check("rst_ad",   {24'd0, ad},   {24'd0, RELEASED});
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Read addr 2: exact done latency, busy profile, address on bus
        req = 1'b1; addr = 2'd2;
        tick();
        req = 1'b0;
        check("addr_phase_ale", {31'd0, ale}, 32'd1);
        check("addr_phase_ad",  {24'd0, ad},  32'h02);
        check("busy_after_e0",  {31'd0, busy}, 32'd1);
        for (int k = 1; k <= DONE_AT + 1; k++) begin
            tick();
            check($sformatf("done_k%0d", k), {31'd0, done}, (k == DONE_AT) ? 32'd1 : 32'd0);
            if (k == DONE_AT)     check("busy_in_done", {31'd0, busy}, 32'd1);
            if (k == DONE_AT + 1) check("busy_cleared", {31'd0, busy}, 32'd0);
        end
        check("data_addr2",  {24'd0, data}, 32'h5A);
        check("model_sel2",  {30'd0, sel_q}, 32'd2);
        check("wr_held",     {31'd0, wr},   32'd1);

        // Read addr 0: byte is bits [8:1] of a 9-bit count
        start_req(2'd0);
        wait_done(c);
        check("lat_addr0",  c, DONE_AT);
        check("data_addr0", {24'd0, data}, 32'hF9);
        tick();

        // req pulsed mid-read is ignored
        start_req(2'd3);
        tick(); tick();
        req = 1'b1; addr = 2'd1;
        tick();
        req = 1'b0;
        ndone = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (done) ndone++;
        end
        check("ignored_req_dones", ndone, 1);
        check("data_addr3",        {24'd0, data}, 32'h3C);

        // req held high: back-to-back reads, addr re-sampled
        req = 1'b1; addr = 2'd1;
        tick();
        addr = 2'd3;
        wait_done(c1);
        check("b2b_data1", {24'd0, data}, 32'hC3);
        wait_done(c2);
        req = 1'b0;
        check("b2b_spacing", c2, SPACING);
        check("b2b_data2", {24'd0, data}, 32'h3C);
        repeat (10) tick();

        // Async reset while rd is low aborts the read
        start_req(2'd1);
        repeat (DONE_AT - 1) tick();
        check("abort_rd_low", {31'd0, rd}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_rd",   {31'd0, rd},   32'd1);
        check("abort_ale",  {31'd0, ale},  32'd0);
        check("abort_ad",   {24'd0, ad},   {24'd0, RELEASED});
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_data", {24'd0, data}, 32'd0);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done || busy) ndone++;
        end
        check("abort_no_done", ndone, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
